// File: rtl/paddle_cmd_tx.sv
// paddle_cmd_tx: debounces the left/right paddle buttons, encodes them as
// 'l'/'r'/'d' command bytes and sends each one as an 8N1 UART frame.
// A frame is sent when the command changes and as a periodic refresh.
module paddle_cmd_tx #(
  parameter int unsigned CLKS_PER_BIT    = 10417,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REFRESH_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic       tx,
  output logic       tx_busy,
  output logic [7:0] cmd_byte
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

  localparam logic [7:0] CMD_LEFT  = 8'h6C;
  localparam logic [7:0] CMD_RIGHT = 8'h72;
  localparam logic [7:0] CMD_NONE  = 8'h64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // Button path: bit 0 is left, bit 1 is right.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       stable_q, stable_d;
  logic [DEB_W-1:0] db_l_cnt_q, db_l_cnt_d;
  logic [DEB_W-1:0] db_r_cnt_q, db_r_cnt_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;

  // Transmit path.
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        last_sent_q, last_sent_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic              ref_due_q, ref_due_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  // Next {stable, counter} of one debouncer: a change is accepted only after
  // DEBOUNCE_CYCLES consecutive cycles of disagreement.
  function automatic logic [DEB_W:0] debounce_next(input logic             sync,
                                                   input logic             stable,
                                                   input logic [DEB_W-1:0] cnt);
    logic [DEB_W:0] res;
    res = {stable, cnt + DEB_W'(1)};
    if (sync == stable) begin
      res = {stable, DEB_W'(0)};
    end else if (cnt == DEB_LAST) begin
      res = {sync, DEB_W'(0)};
    end
    return res;
  endfunction

  // Synchronise, debounce and encode the buttons.
  always_comb begin
    sync1_d = {btn_r, btn_l};
    sync2_d = sync1_q;
    {stable_d[0], db_l_cnt_d} = debounce_next(sync2_q[0], stable_q[0], db_l_cnt_q);
    {stable_d[1], db_r_cnt_d} = debounce_next(sync2_q[1], stable_q[1], db_r_cnt_q);
    case (stable_q)
      2'b01:   cmd_byte_d = CMD_LEFT;
      2'b10:   cmd_byte_d = CMD_RIGHT;
      default: cmd_byte_d = CMD_NONE;
    endcase
  end

  // Send decision, refresh timer and UART framing FSM.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    last_sent_d = last_sent_q;
    ref_cnt_d   = ref_cnt_q;
    ref_due_d   = ref_due_q;
    tx_d        = tx_q;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if ((cmd_byte_q != last_sent_q) || ref_due_q) begin
          state_d     = ST_START;
          shift_d     = cmd_byte_q;
          last_sent_d = cmd_byte_q;
          ref_cnt_d   = '0;
          ref_due_d   = 1'b0;
          baud_cnt_d  = '0;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
        end else begin
          if (ref_cnt_q != REF_LAST) begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
          end
          if (ref_cnt_d == REF_LAST) begin
            ref_due_d = 1'b1;
          end
        end
      end

      ST_START: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = ST_DATA;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      ST_DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      ST_STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          state_d    = ST_IDLE;
          tx_d       = 1'b1;
          busy_d     = 1'b0;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; last_sent resets to 0x00 so a 'd' frame follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      db_l_cnt_q  <= '0;
      db_r_cnt_q  <= '0;
      cmd_byte_q  <= CMD_NONE;
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      last_sent_q <= 8'h00;
      ref_cnt_q   <= '0;
      ref_due_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      db_l_cnt_q  <= db_l_cnt_d;
      db_r_cnt_q  <= db_r_cnt_d;
      cmd_byte_q  <= cmd_byte_d;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      last_sent_q <= last_sent_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_due_q   <= ref_due_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign cmd_byte = cmd_byte_q;

endmodule

// File: tb/tb_paddle_cmd_tx.sv
// Bench for paddle_cmd_tx: cycle model of the button/command/frame rules,
// an independent UART line decoder, scenario table and corner sequences.
module tb_paddle_cmd_tx;

  localparam int CPB   = 4;
  localparam int DEB   = 8;
  localparam int REF   = 200;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       btn_l;
  logic       btn_r;
  logic       tx;
  logic       tx_busy;
  logic [7:0] cmd_byte;

  int checks   = 0;
  int failures = 0;

  paddle_cmd_tx #(
    .CLKS_PER_BIT   (CPB),
    .DEBOUNCE_CYCLES(DEB),
    .REFRESH_CYCLES (REF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_l   (btn_l),
    .btn_r   (btn_r),
    .tx      (tx),
    .tx_busy (tx_busy),
    .cmd_byte(cmd_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Buttons: two-sample delay, then a stable value that follows only after
  // DEB consecutive disagreeing samples. Command = encode(stable), one cycle
  // late. Frames: a running cycle count since frame start gives the line level.
  bit         m_s1 [2];
  bit         m_s2 [2];
  bit         m_st [2];
  int         m_run[2];
  logic [7:0] m_cmd;
  logic [7:0] m_last;
  logic [7:0] m_byte;
  bit         m_busy;
  int         m_ft;
  int         m_idle;

  function automatic logic [7:0] encode(input bit l, input bit r);
    if (l && !r) return 8'h6C;
    if (r && !l) return 8'h72;
    return 8'h64;
  endfunction

  function automatic bit m_tx();
    if (!m_busy)        return 1'b1;
    if (m_ft < CPB)     return 1'b0;
    if (m_ft < 9 * CPB) return m_byte[3'((m_ft - CPB) / CPB)];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0;
    end
    m_cmd = 8'h64; m_last = 8'h00; m_byte = 8'h00;
    m_busy = 0; m_ft = 0; m_idle = 0;
  endtask

  task automatic model_edge();
    bit         os2[2];
    bit         ost[2];
    logic [7:0] ocmd;
    if (rst) begin
      model_reset();
      return;
    end
    ocmd = m_cmd;
    for (int i = 0; i < 2; i++) begin
      os2[i] = m_s2[i];
      ost[i] = m_st[i];
      m_s2[i] = m_s1[i];
    end
    m_s1[0] = btn_l;
    m_s1[1] = btn_r;
    for (int i = 0; i < 2; i++) begin
      if (os2[i] != ost[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          m_st[i]  = os2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_cmd = encode(ost[0], ost[1]);
    if (m_busy) begin
      m_ft = m_ft + 1;
      if (m_ft == FRAME) begin
        m_busy = 0;
        m_idle = 0;
      end
    end else if (ocmd != m_last || m_idle >= REF - 1) begin
      m_busy = 1; m_ft = 0; m_byte = ocmd; m_last = ocmd; m_idle = 0;
    end else begin
      m_idle = m_idle + 1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("lockstep{tx,busy,cmd}", 32'({tx, tx_busy, cmd_byte}),
        32'({m_tx(), m_busy, m_cmd}));
  endtask

  task automatic wait_busy(input logic lvl, input int bound, output int n);
    n = 0;
    while (tx_busy !== lvl && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (tx_busy !== lvl) begin
      failures++;
      $display("FAIL wait_busy: got busy=%b expected %b within %0d cycles", tx_busy, lvl, bound);
    end
  endtask

  // ---------------- UART line decoder ----------------
  logic [7:0] rx_q[$];
  int         rx_bad = 0;
  bit         d_act  = 0;
  int         d_cnt  = 0;
  logic [9:0] d_bits = '0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      d_act = 0;
    end else begin
      if (!d_act && tx === 1'b0) begin
        d_act = 1;
        d_cnt = 0;
      end
      if (d_act) begin
        if (d_cnt % CPB == CPB / 2) d_bits = {tx, d_bits[9:1]};
        if (d_cnt == 9 * CPB + CPB / 2) begin
          d_act = 0;
          if (d_bits[0] !== 1'b0 || d_bits[9] !== 1'b1) rx_bad++;
          rx_q.push_back(d_bits[8:1]);
        end
        d_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit         l;
    bit         r;
    int         hold;
    logic [7:0] exp_cmd;
    int         exp_frames;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int n0;
    int gap;

    vecs[0] = '{l: 0, r: 0, hold: 60,  exp_cmd: 8'h64, exp_frames: 1, exp_last: 8'h64};
    vecs[1] = '{l: 1, r: 0, hold: 80,  exp_cmd: 8'h6C, exp_frames: 1, exp_last: 8'h6C};
    vecs[2] = '{l: 1, r: 1, hold: 5,   exp_cmd: 8'h6C, exp_frames: 0, exp_last: 8'h00};
    vecs[3] = '{l: 1, r: 0, hold: 40,  exp_cmd: 8'h6C, exp_frames: 0, exp_last: 8'h00};
    vecs[4] = '{l: 1, r: 1, hold: 80,  exp_cmd: 8'h64, exp_frames: 1, exp_last: 8'h64};
    vecs[5] = '{l: 0, r: 0, hold: 250, exp_cmd: 8'h64, exp_frames: 1, exp_last: 8'h64};

    model_reset();
    rst   = 1'b1;
    btn_l = 1'b0;
    btn_r = 1'b0;
    repeat (5) tick();
    chk("reset_tx", 32'(tx), 32'(1));
    chk("reset_busy", 32'(tx_busy), 32'(0));
    chk("reset_cmd", 32'(cmd_byte), 32'h64);
    rst = 1'b0;

    // First cycle after release is the decision; the start bit follows.
    tick();
    chk("release_busy", 32'(tx_busy), 32'(1));
    chk("release_tx", 32'(tx), 32'(0));

    for (int i = 0; i < 6; i++) begin
      n0    = rx_q.size();
      btn_l = vecs[i].l;
      btn_r = vecs[i].r;
      repeat (vecs[i].hold - ((i == 0) ? 1 : 0)) tick();
      chk($sformatf("vec%0d_cmd", i), 32'(cmd_byte), 32'(vecs[i].exp_cmd));
      chk($sformatf("vec%0d_frames", i), 32'(rx_q.size() - n0), 32'(vecs[i].exp_frames));
      if (vecs[i].exp_frames > 0 && rx_q.size() > 0)
        chk($sformatf("vec%0d_byte", i), 32'(rx_q[$]), 32'(vecs[i].exp_last));
    end

    // Refresh: exactly REF idle cycles between the end of one frame and the next.
    wait_busy(1'b1, 400, n);
    wait_busy(1'b0, 100, n);
    n0 = rx_q.size();
    wait_busy(1'b1, 400, gap);
    chk("refresh_gap", 32'(gap), 32'(REF));
    wait_busy(1'b0, 100, n);
    chk("refresh_count", 32'(rx_q.size() - n0), 32'(1));
    if (rx_q.size() > 0) chk("refresh_byte", 32'(rx_q[$]), 32'h64);

    // Command change mid-frame: 'l' frame completes, 'r' follows after a 1-cycle gap.
    btn_l = 1'b1;
    btn_r = 1'b0;
    wait_busy(1'b1, 100, n);
    repeat (3) tick();
    btn_l = 1'b0;
    btn_r = 1'b1;
    wait_busy(1'b0, 100, n);
    chk("midframe_cmd", 32'(cmd_byte), 32'h72);
    chk("gap_tx", 32'(tx), 32'(1));
    tick();
    chk("restart_tx", 32'(tx), 32'(0));
    chk("restart_busy", 32'(tx_busy), 32'(1));
    wait_busy(1'b0, 100, n);
    if (rx_q.size() >= 2) begin
      chk("midframe_first", 32'(rx_q[rx_q.size() - 2]), 32'h6C);
      chk("midframe_second", 32'(rx_q[$]), 32'h72);
    end else begin
      chk("midframe_frames", 32'(rx_q.size()), 32'(2));
    end

    // Reset in the middle of the data bits aborts the frame; a 'd' frame follows.
    btn_r = 1'b0;
    wait_busy(1'b1, 100, n);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("abort_tx", 32'(tx), 32'(1));
    chk("abort_busy", 32'(tx_busy), 32'(0));
    repeat (2) tick();
    n0  = rx_q.size();
    rst = 1'b0;
    wait_busy(1'b1, 10, n);
    chk("abort_restart_latency", 32'(n), 32'(1));
    wait_busy(1'b0, 100, n);
    chk("abort_frames", 32'(rx_q.size() - n0), 32'(1));
    if (rx_q.size() > 0) chk("abort_byte", 32'(rx_q[$]), 32'h64);

    // Random buttons and occasional resets, checked cycle by cycle.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end else begin
        btn_l = 1'($urandom_range(0, 1));
        btn_r = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 25)) tick();
      end
    end
    repeat (2 * FRAME) tick();

    chk("framing_errors", 32'(rx_bad), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
